// File: rtl/ber_sync_checker_pkg.sv
// Shared state encoding and default sizing for the BER sync checker.
// Every file of the checker imports this package.
package ber_sync_checker_pkg;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   localparam int DELAY_MAX_DEF = 511;
   localparam int NB_DLY_DEF    = 9;
   localparam int WIN_LEN_DEF   = 256;
   localparam int LOSS_THR_DEF  = 16;
   localparam int NB_CNT_DEF    = 64;

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line: a shift register with a delay-select tap.
// Tap 0 is the live input; tap d (d>0) is the bit shifted in d steps ago.
module ber_delay_line
   import ber_sync_checker_pkg::*;
#(
   parameter int DELAY_MAX = DELAY_MAX_DEF,
   parameter int NB_DLY    = NB_DLY_DEF
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              din,
   input  logic [NB_DLY-1:0] delay,
   output logic              ref_d
);

   logic [DELAY_MAX-1:0] sr_r;

   // Shift the reference history by one position per step.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sr_r <= '0;
      end else if (shift_en) begin
         sr_r <= {sr_r[DELAY_MAX-2:0], din};
      end else begin
         sr_r <= sr_r;
      end
   end

   // Select the delayed reference from the pre-shift contents.
   always_comb begin
      ref_d = 1'b0;
      if (delay == '0) begin
         ref_d = din;
      end else if (int'(delay) <= DELAY_MAX) begin
         ref_d = sr_r[delay - NB_DLY'(1)];
      end else begin
         ref_d = 1'b0;
      end
   end

endmodule

// File: rtl/ber_sync_checker.sv
// BER sync checker: searches the delay between the recovered and reference
// bit streams, locks onto it, then counts compared bits and errors.
module ber_sync_checker
   import ber_sync_checker_pkg::*;
#(
   parameter int DELAY_MAX = DELAY_MAX_DEF,
   parameter int NB_DLY    = NB_DLY_DEF,
   parameter int WIN_LEN   = WIN_LEN_DEF,
   parameter int LOSS_THR  = LOSS_THR_DEF,
   parameter int NB_CNT    = NB_CNT_DEF
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_valid,
   input  logic              i_ref_bit,
   input  logic              i_rx_bit,
   output logic              o_locked,
   output logic [NB_DLY-1:0] o_delay,
   output logic [NB_CNT-1:0] o_bit_count,
   output logic [NB_CNT-1:0] o_err_count,
   output logic              o_match
);

   localparam int                NB_WIN    = $clog2(WIN_LEN + 1);
   localparam logic [NB_WIN-1:0] WIN_LAST  = NB_WIN'(WIN_LEN - 1);
   localparam logic [NB_WIN-1:0] LOSS_LIM  = NB_WIN'(LOSS_THR);
   localparam logic [NB_DLY-1:0] DLY_LAST  = NB_DLY'(DELAY_MAX);
   localparam logic [NB_DLY-1:0] FILL_LAST = NB_DLY'(DELAY_MAX - 1);
   localparam logic [NB_CNT-1:0] CNT_MAX   = {NB_CNT{1'b1}};

   state_t              state_r, state_next_s;
   logic [NB_DLY-1:0]   delay_r, delay_next_s;
   logic [NB_DLY-1:0]   fill_r, fill_next_s;
   logic [NB_WIN-1:0]   win_cnt_r, win_cnt_next_s;
   logic [NB_WIN-1:0]   win_err_r, win_err_next_s;
   logic [NB_CNT-1:0]   bit_cnt_r, bit_next_s;
   logic [NB_CNT-1:0]   err_cnt_r, err_next_s;
   logic                match_r, match_next_s;
   logic                locked_r;
   logic                step_s, ref_d_s, err_s, win_end_s;
   logic [NB_WIN-1:0]   win_sum_s;

   assign step_s    = i_enable & i_valid;
   assign err_s     = ref_d_s ^ i_rx_bit;
   assign win_sum_s = win_err_r + NB_WIN'(err_s);
   assign win_end_s = (win_cnt_r == WIN_LAST);

   ber_delay_line #(
      .DELAY_MAX (DELAY_MAX),
      .NB_DLY    (NB_DLY)
   ) u_delay_line (
      .clock    (clock),
      .rst_n    (i_reset),
      .shift_en (step_s),
      .din      (i_ref_bit),
      .delay    (delay_r),
      .ref_d    (ref_d_s)
   );

   // Register state, window and measurement counters.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state_r   <= ST_FILL;
         delay_r   <= '0;
         fill_r    <= '0;
         win_cnt_r <= '0;
         win_err_r <= '0;
         bit_cnt_r <= '0;
         err_cnt_r <= '0;
         match_r   <= 1'b0;
         locked_r  <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         delay_r   <= delay_next_s;
         fill_r    <= fill_next_s;
         win_cnt_r <= win_cnt_next_s;
         win_err_r <= win_err_next_s;
         bit_cnt_r <= bit_next_s;
         err_cnt_r <= err_next_s;
         match_r   <= match_next_s;
         locked_r  <= (state_next_s == ST_LOCK);
      end
   end

   // Next-state and counter update, evaluated only on a valid step.
   always_comb begin
      state_next_s   = state_r;
      delay_next_s   = delay_r;
      fill_next_s    = fill_r;
      win_cnt_next_s = win_cnt_r;
      win_err_next_s = win_err_r;
      bit_next_s     = bit_cnt_r;
      err_next_s     = err_cnt_r;
      match_next_s   = match_r;
      if (step_s) begin
         case (state_r)
            ST_FILL: begin
               if (fill_r == FILL_LAST) begin
                  state_next_s   = ST_SEARCH;
                  fill_next_s    = '0;
                  delay_next_s   = '0;
                  win_cnt_next_s = '0;
                  win_err_next_s = '0;
               end else begin
                  fill_next_s = fill_r + NB_DLY'(1);
               end
            end
            ST_SEARCH: begin
               if (win_end_s) begin
                  win_cnt_next_s = '0;
                  win_err_next_s = '0;
                  if (win_sum_s == '0) begin
                     state_next_s = ST_LOCK;
                     bit_next_s   = '0;
                     err_next_s   = '0;
                  end else if (delay_r == DLY_LAST) begin
                     delay_next_s = '0;
                  end else begin
                     delay_next_s = delay_r + NB_DLY'(1);
                  end
               end else begin
                  win_cnt_next_s = win_cnt_r + NB_WIN'(1);
                  win_err_next_s = win_sum_s;
               end
            end
            ST_LOCK: begin
               // Saturating measurement counters; they never wrap.
               if (bit_cnt_r == CNT_MAX) begin
                  bit_next_s = bit_cnt_r;
               end else begin
                  bit_next_s = bit_cnt_r + NB_CNT'(1);
               end
               if (err_s && (err_cnt_r != CNT_MAX)) begin
                  err_next_s = err_cnt_r + NB_CNT'(1);
               end else begin
                  err_next_s = err_cnt_r;
               end
               match_next_s = ~err_s;
               if (win_end_s) begin
                  win_cnt_next_s = '0;
                  win_err_next_s = '0;
                  if (win_sum_s > LOSS_LIM) begin
                     state_next_s = ST_SEARCH;
                     match_next_s = 1'b0;
                  end else begin
                     state_next_s = ST_LOCK;
                  end
               end else begin
                  win_cnt_next_s = win_cnt_r + NB_WIN'(1);
                  win_err_next_s = win_sum_s;
               end
            end
            default: begin
               state_next_s   = ST_FILL;
               fill_next_s    = '0;
               win_cnt_next_s = '0;
               win_err_next_s = '0;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   assign o_locked    = locked_r;
   assign o_delay     = delay_r;
   assign o_bit_count = bit_cnt_r;
   assign o_err_count = err_cnt_r;
   assign o_match     = match_r;

endmodule

// File: tb/tb_ber_sync_checker.sv
// Randomized bench for ber_sync_checker with a step-level reference model,
// run at reduced sizes so every scenario (including delay wrap) stays short.
module tb_ber_sync_checker;

   localparam int DM = 63;
   localparam int ND = 6;
   localparam int WL = 32;
   localparam int LT = 4;
   localparam int NC = 10;
   localparam longint CMAX = (64'd1 << NC) - 64'd1;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          en, vld, refb, rxb;
   logic          locked, match;
   logic [ND-1:0] dly;
   logic [NC-1:0] bitc, errc;

   int total = 0;
   int bad   = 0;

   // stream source: PRBS9 reference, rx = reference delayed/inverted/flipped
   logic [8:0] lfsr;
   bit   ghist [0:255];
   int   gk = 0;
   int   src_delay = 37;
   bit   src_inv = 1'b0;
   int   flip_cnt = 0;

   // reference model, defined on the sequence of accepted steps
   int     m_state, m_fill, m_wcnt, m_werr, m_dly, m_s;
   longint m_bit, m_err;
   bit     m_match, m_locked;
   bit     mh [0:255];

   int  steps = 0;
   bit  seen_lock, wrapped;
   int  prev_dly = 0;

   ber_sync_checker #(
      .DELAY_MAX (DM),
      .NB_DLY    (ND),
      .WIN_LEN   (WL),
      .LOSS_THR  (LT),
      .NB_CNT    (NC)
   ) dut (
      .clock       (clock),
      .i_reset     (rst_n),
      .i_enable    (en),
      .i_valid     (vld),
      .i_ref_bit   (refb),
      .i_rx_bit    (rxb),
      .o_locked    (locked),
      .o_delay     (dly),
      .o_bit_count (bitc),
      .o_err_count (errc),
      .o_match     (match)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit prbs_next();
      bit b;
      b = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], b};
      return b;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_fill = 0; m_wcnt = 0; m_werr = 0; m_dly = 0; m_s = 0;
      m_bit = 0; m_err = 0; m_match = 1'b0; m_locked = 1'b0;
   endfunction

   function automatic void model_step(input bit r, input bit x);
      bit rd, e;
      if (m_dly == 0) rd = r;
      else if (m_s >= m_dly) rd = mh[(m_s - m_dly) % 256];
      else rd = 1'b0;
      e = rd ^ x;
      mh[m_s % 256] = r;
      m_s++;
      if (m_state == 0) begin
         m_fill++;
         if (m_fill == DM) begin
            m_state = 1; m_dly = 0; m_wcnt = 0; m_werr = 0;
         end
      end else if (m_state == 1) begin
         m_werr += int'(e);
         m_wcnt++;
         if (m_wcnt == WL) begin
            if (m_werr == 0) begin
               m_state = 2; m_bit = 0; m_err = 0;
            end else begin
               m_dly = (m_dly == DM) ? 0 : m_dly + 1;
            end
            m_wcnt = 0; m_werr = 0;
         end
      end else begin
         m_bit = (m_bit + 1 > CMAX) ? CMAX : m_bit + 1;
         m_err = (m_err + longint'(e) > CMAX) ? CMAX : m_err + longint'(e);
         m_match = ~e;
         m_werr += int'(e);
         m_wcnt++;
         if (m_wcnt == WL) begin
            if (m_werr > LT) begin
               m_state = 1; m_match = 1'b0;
            end
            m_wcnt = 0; m_werr = 0;
         end
      end
      m_locked = (m_state == 2);
   endfunction

   task automatic tick();
      bit b, x, f;
      @(negedge clock);
      en  = ($urandom_range(15, 0) != 0);
      vld = ($urandom_range(3, 0) != 0);
      if (en && vld) begin
         b = prbs_next();
         ghist[gk % 256] = b;
         if (gk >= src_delay) x = ghist[(gk - src_delay) % 256];
         else x = 1'($urandom_range(1, 0));
         f = (flip_cnt > 0);
         if (rst_n && flip_cnt > 0) flip_cnt--;
         gk++;
         refb = b;
         rxb  = x ^ src_inv ^ f;
      end else begin
         refb = 1'($urandom_range(1, 0));
         rxb  = 1'($urandom_range(1, 0));
      end
      @(posedge clock);
      if (en && vld && rst_n) begin
         model_step(refb, rxb);
         steps++;
      end
      #1;
      check_val("locked", longint'(locked), longint'(m_locked));
      check_val("delay", longint'(dly), longint'(m_dly));
      check_val("bit_count", longint'(bitc), m_bit);
      check_val("err_count", longint'(errc), m_err);
      check_val("match", longint'(match), longint'(m_match));
      if (locked) seen_lock = 1'b1;
      if (prev_dly == DM && int'(dly) == 0) wrapped = 1'b1;
      prev_dly = int'(dly);
   endtask

   task automatic run_steps(input int n);
      int target, budget;
      target = steps + n;
      budget = n * 8 + 64;
      while (steps < target && budget > 0) begin
         tick();
         budget--;
      end
      if (steps < target) check_val("step_budget", steps, target);
   endtask

   task automatic wait_win_start();
      int guard;
      guard = 0;
      while (m_wcnt != 0 && guard < 4 * WL) begin
         run_steps(1);
         guard++;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; vld = 1'b0; refb = 1'b0; rxb = 1'b0;
      lfsr = 9'h1FF;
      model_reset();

      // reset held with valids toggling
      repeat (8) tick();
      check_val("rst_locked", longint'(locked), 0);
      check_val("rst_delay", longint'(dly), 0);
      check_val("rst_bitc", longint'(bitc), 0);
      check_val("rst_errc", longint'(errc), 0);
      check_val("rst_match", longint'(match), 0);
      rst_n = 1'b1;

      // aligned stream at delay 37
      run_steps(DM);
      check_val("fill_locked", longint'(locked), 0);
      check_val("fill_delay", longint'(dly), 0);
      run_steps(38 * WL - 1);
      check_val("prelock", longint'(locked), 0);
      run_steps(1);
      check_val("lock37", longint'(locked), 1);
      check_val("lock37_delay", longint'(dly), 37);
      check_val("lock37_errc", longint'(errc), 0);
      run_steps(1000);
      check_val("bitc_1000", longint'(bitc), 1000);
      run_steps(100);
      check_val("bitc_sat", longint'(bitc), CMAX);

      // single error
      flip_cnt = 1;
      run_steps(1);
      check_val("single_errc", longint'(errc), 1);
      check_val("single_match", longint'(match), 0);
      check_val("single_locked", longint'(locked), 1);
      run_steps(1);
      check_val("single_match_back", longint'(match), 1);

      // loss of lock, then relock at the same delay
      wait_win_start();
      flip_cnt = LT + 2;
      run_steps(WL);
      check_val("loss_locked", longint'(locked), 0);
      check_val("loss_delay", longint'(dly), 37);
      check_val("loss_match", longint'(match), 0);
      run_steps(WL);
      check_val("relock", longint'(locked), 1);
      check_val("relock_delay", longint'(dly), 37);
      check_val("relock_bitc", longint'(bitc), 0);
      check_val("relock_errc", longint'(errc), 0);
      run_steps(10);

      // asynchronous reset pulse between edges while locked
      @(posedge clock);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_locked", longint'(locked), 0);
      check_val("arst_delay", longint'(dly), 0);
      check_val("arst_bitc", longint'(bitc), 0);
      check_val("arst_errc", longint'(errc), 0);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;

      // zero delay restart
      src_delay = 0;
      run_steps(DM + WL - 1);
      check_val("zd_prelock", longint'(locked), 0);
      run_steps(1);
      check_val("zd_lock", longint'(locked), 1);
      check_val("zd_delay", longint'(dly), 0);

      // inverted stream: never locks, delay wraps
      src_delay = 37;
      src_inv = 1'b1;
      rst_n = 1'b0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      seen_lock = 1'b0;
      wrapped = 1'b0;
      run_steps(DM + 64 * WL - 1);
      check_val("inv_last_delay", longint'(dly), DM);
      run_steps(1);
      check_val("inv_wrap_delay", longint'(dly), 0);
      check_val("inv_wrapped", longint'(wrapped), 1);
      check_val("inv_never_locked", longint'(seen_lock), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
